fetch_unit: RTL and testbench

//  Instruction-fetch requester driving the BRAM instruction memory port (index/en -> rdata/rvalid).

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Holds the fetch buffer entry, the in-flight request tag and a word-alignment helper.
package cpu_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] insn;
   } fetch_entry_t;

   typedef struct packed {
      logic            v;
      logic [XLEN-1:0] pc;
   } fetch_req_t;

   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries between the memory response path and decode.
// Flush wins over push and pop in the same cycle; head is read combinationally from storage.
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  fetch_entry_t           wdata,
   output fetch_entry_t           rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t    mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign do_push = push && !flush;
   assign do_pop  = pop && !flush && !empty;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign rdata = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: nothing is visible until count says so.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && full && !flush));

   a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(pop && empty && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch requester: owns the PC, issues word requests to a fixed-latency BRAM,
// tags them through an in-flight pipe and buffers the responses toward decode.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4,
   parameter int          IC_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [29:0] ic_index,
   output logic        ic_en,
   input  logic [31:0] ic_rdata,
   input  logic        ic_rvalid,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [XLEN-1:0] pc;
   logic            active;
   fetch_req_t      pipe [IC_LATENCY];
   fetch_req_t      tail;
   logic [XLEN-1:0] held_pc;

   logic [CW-1:0]   fifo_count;
   logic            fifo_full;
   logic            fifo_empty;
   fetch_entry_t    head;
   fetch_entry_t    push_entry;

   logic [31:0]     inflight_count;
   logic [31:0]     occupancy;
   logic            issue;
   logic            push;
   logic            pop;

   assign tail = pipe[IC_LATENCY-1];

   // The registered FIFO count ignores this cycle's pop, so a credit is only
   // returned the cycle after decode takes an entry; memory can never be stalled.
   always_comb begin
      inflight_count = '0;
      for (int i = 0; i < IC_LATENCY; i++) begin
         inflight_count = inflight_count + 32'(pipe[i].v);
      end
      occupancy = 32'(fifo_count) + inflight_count;
      issue     = active && !redirect_valid && (occupancy < 32'(FIFO_DEPTH));
   end

   assign push       = ic_rvalid && tail.v;
   assign pop        = inst_valid && inst_ready;
   assign push_entry = '{pc: tail.pc, insn: ic_rdata};

   assign ic_en    = issue;
   assign ic_index = pc[31:2];

   // active holds issue off until the first edge after reset is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc     <= RESET_PC;
         active <= 1'b0;
         for (int i = 0; i < IC_LATENCY; i++) begin
            pipe[i] <= '0;
         end
      end else begin
         active <= 1'b1;
         if (redirect_valid) begin
            pc <= align_word(redirect_pc);
         end else if (issue) begin
            pc <= pc + 32'd4;
         end
         pipe[0] <= '{v: issue, pc: pc};
         for (int i = 1; i < IC_LATENCY; i++) begin
            pipe[i] <= '{v: pipe[i-1].v && !redirect_valid, pc: pipe[i-1].pc};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held_pc <= '0;
      end else if (pop && !redirect_valid) begin
         held_pc <= head.pc;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .wdata (push_entry),
      .rdata (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign inst_valid = !fifo_empty;
   assign inst_data  = fifo_empty ? NOP_INSN : head.insn;
   assign inst_pc    = fifo_empty ? held_pc : head.pc;

   a_response_expected: assert property (@(posedge clk) disable iff (!rst_n)
      !(tail.v && !ic_rvalid));

   a_fifo_never_full_on_push: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && fifo_full && !redirect_valid));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two-cycle BRAM models with mem[i] = 0x1000_0000 + i, and an
// in-order expected-PC stream model that follows redirects and resets.
module tb_fetch_unit;
   import cpu_pkg::*;

   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic [29:0] ic_index;
   logic        ic_en;
   logic [31:0] ic_rdata;
   logic        ic_rvalid;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;

   logic [29:0] ic_index_w;
   logic        ic_en_w;
   logic [31:0] ic_rdata_w;
   logic        ic_rvalid_w;
   logic        redirect_valid_w = 1'b0;
   logic [31:0] redirect_pc_w = '0;
   logic        inst_valid_w;
   logic        inst_ready_w = 1'b1;
   logic [31:0] inst_data_w;
   logic [31:0] inst_pc_w;

   int          checks = 0;
   int          passes = 0;
   logic [31:0] exp_pc;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ic_index       (ic_index),
      .ic_en          (ic_en),
      .ic_rdata       (ic_rdata),
      .ic_rvalid      (ic_rvalid),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc)
   );

   fetch_unit #(
      .RESET_PC (WRAP_PC)
   ) dut_w (
      .clk            (clk),
      .rst_n          (rst_n),
      .ic_index       (ic_index_w),
      .ic_en          (ic_en_w),
      .ic_rdata       (ic_rdata_w),
      .ic_rvalid      (ic_rvalid_w),
      .redirect_valid (redirect_valid_w),
      .redirect_pc    (redirect_pc_w),
      .inst_valid     (inst_valid_w),
      .inst_ready     (inst_ready_w),
      .inst_data      (inst_data_w),
      .inst_pc        (inst_pc_w)
   );

   // Memory models are not reset, so requests issued before a reset still return.
   logic        m_en0 = 1'b0, m_en1 = 1'b0;
   logic [29:0] m_idx0 = '0, m_idx1 = '0;
   logic        w_en0 = 1'b0, w_en1 = 1'b0;
   logic [29:0] w_idx0 = '0, w_idx1 = '0;

   always @(posedge clk) begin
      m_en0  <= ic_en;
      m_idx0 <= ic_index;
      m_en1  <= m_en0;
      m_idx1 <= m_idx0;
      w_en0  <= ic_en_w;
      w_idx0 <= ic_index_w;
      w_en1  <= w_en0;
      w_idx1 <= w_idx0;
   end

   assign ic_rvalid   = m_en1;
   assign ic_rdata    = 32'h1000_0000 + {2'b00, m_idx1};
   assign ic_rvalid_w = w_en1;
   assign ic_rdata_w  = 32'h1000_0000 + {2'b00, w_idx1};

   function automatic logic [31:0] word_at(input logic [31:0] byte_pc);
      return 32'h1000_0000 + (byte_pc >> 2);
   endfunction

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [31:0] wp;
      wp = WRAP_PC;
      rst_n = 1'b0;
      inst_ready = 1'b1;
      redirect_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (ic_en !== 1'b0) $display("[TB] FAIL reset_ic_en: got %b want 0", ic_en); else passes++;
      checks++; if (inst_valid !== 1'b0) $display("[TB] FAIL reset_inst_valid: got %b want 0", inst_valid); else passes++;
      checks++; if (inst_data !== NOP_INSN) $display("[TB] FAIL reset_inst_data: got %h want %h", inst_data, NOP_INSN); else passes++;
      checks++; if (inst_pc !== 32'h0) $display("[TB] FAIL reset_inst_pc: got %h want 0", inst_pc); else passes++;
      checks++; if (ic_index !== 30'h0) $display("[TB] FAIL reset_ic_index: got %h want 0", ic_index); else passes++;
      checks++; if (ic_index_w !== wp[31:2]) $display("[TB] FAIL reset_ic_index_w: got %h want %h", ic_index_w, wp[31:2]); else passes++;
      checks++; if (inst_valid_w !== 1'b0) $display("[TB] FAIL reset_inst_valid_w: got %b want 0", inst_valid_w); else passes++;
   endtask

   task automatic test_wrap();
      logic [31:0] exp_w;
      exp_w = WRAP_PC;
      release_reset();
      for (int c = 0; c < 8; c++) begin
         #1;
         checks++;
         if (inst_valid_w !== (c >= 3)) $display("[TB] FAIL wrap_valid c%0d: got %b want %b", c, inst_valid_w, (c >= 3));
         else passes++;
         if (inst_valid_w) begin
            checks++; if (inst_pc_w !== exp_w) $display("[TB] FAIL wrap_pc: got %h want %h", inst_pc_w, exp_w); else passes++;
            checks++; if (inst_data_w !== word_at(exp_w)) $display("[TB] FAIL wrap_data: got %h want %h", inst_data_w, word_at(exp_w)); else passes++;
            exp_w = exp_w + 32'd4;
         end
         @(negedge clk);
      end
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_stream();
      exp_pc = 32'h0;
      inst_ready = 1'b1;
      release_reset();
      for (int c = 0; c < 16; c++) begin
         #1;
         checks++; if (ic_en !== 1'b1) $display("[TB] FAIL stream_ic_en c%0d: got %b want 1", c, ic_en); else passes++;
         checks++;
         if (inst_valid !== (c >= 3)) $display("[TB] FAIL stream_valid c%0d: got %b want %b", c, inst_valid, (c >= 3));
         else passes++;
         if (inst_valid && inst_ready) begin
            checks++; if (inst_pc !== exp_pc) $display("[TB] FAIL stream_pc: got %h want %h", inst_pc, exp_pc); else passes++;
            checks++; if (inst_data !== word_at(exp_pc)) $display("[TB] FAIL stream_data: got %h want %h", inst_data, word_at(exp_pc)); else passes++;
            exp_pc = exp_pc + 32'd4;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      inst_ready = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      checks++; if (ic_en !== 1'b0) $display("[TB] FAIL bp_ic_en: got %b want 0", ic_en); else passes++;
      checks++; if (inst_valid !== 1'b1) $display("[TB] FAIL bp_valid: got %b want 1", inst_valid); else passes++;
      checks++; if (inst_pc !== exp_pc) $display("[TB] FAIL bp_head_pc: got %h want %h", inst_pc, exp_pc); else passes++;
      checks++;
      if (({ic_index, 2'b00} - exp_pc) !== 32'd16)
         $display("[TB] FAIL bp_buffered_bytes: got %0d want 16", {ic_index, 2'b00} - exp_pc);
      else passes++;
      @(negedge clk);
      inst_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         #1;
         checks++; if (inst_valid !== 1'b1) $display("[TB] FAIL bp_drain_valid c%0d: got %b want 1", c, inst_valid); else passes++;
         if (inst_valid) begin
            checks++; if (inst_pc !== exp_pc) $display("[TB] FAIL bp_drain_pc: got %h want %h", inst_pc, exp_pc); else passes++;
            checks++; if (inst_data !== word_at(exp_pc)) $display("[TB] FAIL bp_drain_data: got %h want %h", inst_data, word_at(exp_pc)); else passes++;
            exp_pc = exp_pc + 32'd4;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_redirect();
      inst_ready = 1'b0;
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc = 32'h40;
      inst_ready = 1'b1;
      #1;
      checks++; if (ic_en !== 1'b0) $display("[TB] FAIL redir_ic_en: got %b want 0", ic_en); else passes++;
      checks++; if (inst_valid !== 1'b1) $display("[TB] FAIL redir_buffered: got %b want 1", inst_valid); else passes++;
      exp_pc = 32'h40;
      @(negedge clk);
      redirect_valid = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         #1;
         if (k == 1) begin
            checks++; if (ic_en !== 1'b1) $display("[TB] FAIL redir_first_issue: got %b want 1", ic_en); else passes++;
            checks++; if (ic_index !== 30'h10) $display("[TB] FAIL redir_first_index: got %h want 10", ic_index); else passes++;
         end
         checks++;
         if (inst_valid !== (k >= 4)) $display("[TB] FAIL redir_valid k%0d: got %b want %b", k, inst_valid, (k >= 4));
         else passes++;
         if (inst_valid && inst_ready) begin
            checks++; if (inst_pc !== exp_pc) $display("[TB] FAIL redir_pc: got %h want %h", inst_pc, exp_pc); else passes++;
            checks++; if (inst_data !== word_at(exp_pc)) $display("[TB] FAIL redir_data: got %h want %h", inst_data, word_at(exp_pc)); else passes++;
            exp_pc = exp_pc + 32'd4;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_redirect_misaligned();
      for (int pass = 0; pass < 2; pass++) begin
         redirect_valid = 1'b1;
         redirect_pc = (pass == 0) ? 32'h43 : 32'h80;
         #1;
         checks++; if (ic_en !== 1'b0) $display("[TB] FAIL redir2_ic_en p%0d: got %b want 0", pass, ic_en); else passes++;
         exp_pc = redirect_pc & ~32'd3;
         if (pass == 1) begin
            @(negedge clk);
            redirect_pc = 32'h100;
            #1;
            checks++; if (ic_en !== 1'b0) $display("[TB] FAIL redir2_b2b_ic_en: got %b want 0", ic_en); else passes++;
            exp_pc = 32'h100;
         end
         @(negedge clk);
         redirect_valid = 1'b0;
         for (int k = 1; k <= 8; k++) begin
            #1;
            checks++;
            if (inst_valid !== (k >= 4)) $display("[TB] FAIL redir2_valid p%0d k%0d: got %b want %b", pass, k, inst_valid, (k >= 4));
            else passes++;
            if (inst_valid && inst_ready) begin
               checks++; if (inst_pc !== exp_pc) $display("[TB] FAIL redir2_pc: got %h want %h", inst_pc, exp_pc); else passes++;
               checks++; if (inst_data !== word_at(exp_pc)) $display("[TB] FAIL redir2_data: got %h want %h", inst_data, word_at(exp_pc)); else passes++;
               exp_pc = exp_pc + 32'd4;
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_async_reset();
      inst_ready = 1'b0;
      @(negedge clk);
      #1;
      checks++; if (inst_valid !== 1'b1) $display("[TB] FAIL areset_pre_valid: got %b want 1", inst_valid); else passes++;
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if (inst_valid !== 1'b0) $display("[TB] FAIL areset_valid: got %b want 0", inst_valid); else passes++;
      checks++; if (inst_data !== NOP_INSN) $display("[TB] FAIL areset_data: got %h want %h", inst_data, NOP_INSN); else passes++;
      checks++; if (inst_pc !== 32'h0) $display("[TB] FAIL areset_pc: got %h want 0", inst_pc); else passes++;
      checks++; if (ic_en !== 1'b0) $display("[TB] FAIL areset_ic_en: got %b want 0", ic_en); else passes++;
      checks++; if (ic_index !== 30'h0) $display("[TB] FAIL areset_ic_index: got %h want 0", ic_index); else passes++;
      inst_ready = 1'b1;
      exp_pc = 32'h0;
      release_reset();
      for (int c = 0; c < 9; c++) begin
         #1;
         checks++;
         if (inst_valid !== (c >= 3)) $display("[TB] FAIL areset_restart_valid c%0d: got %b want %b", c, inst_valid, (c >= 3));
         else passes++;
         if (inst_valid && inst_ready) begin
            checks++; if (inst_pc !== exp_pc) $display("[TB] FAIL areset_restart_pc: got %h want %h", inst_pc, exp_pc); else passes++;
            checks++; if (inst_data !== word_at(exp_pc)) $display("[TB] FAIL areset_restart_data: got %h want %h", inst_data, word_at(exp_pc)); else passes++;
            exp_pc = exp_pc + 32'd4;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_random();
      int accepted;
      accepted = 0;
      for (int c = 0; c < 300; c++) begin
         inst_ready = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 19) == 0);
         redirect_pc = $urandom_range(0, 32'h0000_0FFF);
         #1;
         if (!inst_valid) begin
            checks++; if (inst_data !== NOP_INSN) $display("[TB] FAIL rand_empty_data: got %h want %h", inst_data, NOP_INSN); else passes++;
         end
         if (redirect_valid) begin
            checks++; if (ic_en !== 1'b0) $display("[TB] FAIL rand_redir_ic_en: got %b want 0", ic_en); else passes++;
            exp_pc = redirect_pc & ~32'd3;
         end else if (inst_valid && inst_ready) begin
            checks++; if (inst_pc !== exp_pc) $display("[TB] FAIL rand_pc c%0d: got %h want %h", c, inst_pc, exp_pc); else passes++;
            checks++; if (inst_data !== word_at(exp_pc)) $display("[TB] FAIL rand_data c%0d: got %h want %h", c, inst_data, word_at(exp_pc)); else passes++;
            exp_pc = exp_pc + 32'd4;
            accepted++;
         end
         @(negedge clk);
      end
      redirect_valid = 1'b0;
      checks++; if (accepted <= 50) $display("[TB] FAIL rand_progress: got %0d accepted want > 50", accepted); else passes++;
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_stream();
      test_backpressure();
      test_redirect();
      test_redirect_misaligned();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got %0d/%0d", passes, checks);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
